// File: rtl/enc_cpu_pkg.sv
// Shared definitions for the address scan controller: default widths and
// the scan FSM state type.
package enc_cpu_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int STRIDE_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/addr_scan_ctrl_if.sv
// Request/memory-side bundle of the address scan controller. The master
// modport is the requester and memory side; the slave modport is the controller.
interface addr_scan_ctrl_if
    import enc_cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int STRIDE_W = STRIDE_W_DEF
) ();

    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   length;
    logic [STRIDE_W-1:0] stride;
    logic                abort;
    logic                mem_ready;
    logic [ADDR_W-1:0]   address;
    logic                addr_valid;
    logic                busy;
    logic                done;

    modport master (
        output start, base_addr, length, stride, abort, mem_ready,
        input  address, addr_valid, busy, done
    );

    modport slave (
        input  start, base_addr, length, stride, abort, mem_ready,
        output address, addr_valid, busy, done
    );

endinterface

// File: rtl/addr_step_counter.sv
// Loadable address counter that advances by a zero-extended stride on each
// enable; arithmetic wraps modulo 2^W.
module addr_step_counter #(
    parameter int W  = 16,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          enable,
    input  logic [W-1:0]  load_val,
    input  logic [SW-1:0] stride,
    output logic [W-1:0]  count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (enable) begin
            count_d = count_q + W'(stride);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/addr_scan_ctrl.sv
// Address scan controller: issues `length` addresses from `base_addr` in
// `stride` steps over a valid/ready handshake, then pulses done for one cycle.
module addr_scan_ctrl
    import enc_cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int STRIDE_W = STRIDE_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    addr_scan_ctrl_if.slave  bus
);

    scan_state_t         state_q,     state_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic [STRIDE_W-1:0] stride_q,    stride_d;

    logic                cnt_load;
    logic                cnt_en;
    logic                beat;
    logic [ADDR_W-1:0]   cnt_addr;

    assign beat = (state_q == RUN) && bus.mem_ready;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        stride_d    = stride_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.length != '0) begin
                        state_d     = RUN;
                        remaining_d = bus.length;
                        stride_d    = bus.stride;
                        cnt_load    = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                // Abort wins over a beat accepted on the same edge.
                if (bus.abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (beat) begin
                    cnt_en      = 1'b1;
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q == ADDR_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            stride_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            stride_q    <= stride_d;
        end
    end

    // Loads from the live input so the first address is stride-free.
    addr_step_counter #(
        .W  (ADDR_W),
        .SW (STRIDE_W)
    ) u_step (
        .clk      (clk),
        .rst_n    (reset),
        .load     (cnt_load),
        .enable   (cnt_en),
        .load_val (bus.base_addr),
        .stride   (stride_q),
        .count    (cnt_addr)
    );

    assign bus.address    = cnt_addr;
    assign bus.addr_valid = (state_q == RUN);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE) && !bus.abort;

endmodule

// File: tb/tb_addr_scan_ctrl.sv
// Self-checking bench for addr_scan_ctrl: directed scenarios plus random
// traffic, all compared cycle by cycle against a queue-based scan model.
module tb_addr_scan_ctrl;
    import enc_cpu_pkg::*;

    localparam int AW = 16;
    localparam int SW = 4;

    logic clk;
    logic reset;

    int n_checks   = 0;
    int n_fail     = 0;
    int beats_seen = 0;

    addr_scan_ctrl_if #(.ADDR_W(AW), .STRIDE_W(SW)) bus ();

    addr_scan_ctrl #(.ADDR_W(AW), .STRIDE_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scan model: pending addresses of the active scan, a pending done pulse,
    // and the address the counter holds when no scan is active.
    logic [AW-1:0] exp_q[$];
    bit            m_active;
    bit            m_done_due;
    logic [AW-1:0] m_hold;
    logic [SW-1:0] m_stride;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active   = 1'b0;
        m_done_due = 1'b0;
        m_hold     = '0;
        m_stride   = '0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the model to what the next rising edge must produce.
    task automatic cycle(input bit st, input logic [AW-1:0] b, input logic [AW-1:0] l,
                         input logic [SW-1:0] s, input bit ab, input bit rdy);
        logic [AW-1:0] e_addr;
        logic [AW-1:0] nxt;
        bit            e_busy;
        @(negedge clk);
        bus.start     = st;
        bus.base_addr = b;
        bus.length    = l;
        bus.stride    = s;
        bus.abort     = ab;
        bus.mem_ready = rdy;
        reset         = 1'b1;
        #1;
        e_addr = m_active ? exp_q[0] : m_hold;
        e_busy = m_active || m_done_due;
        check("addr_valid", 32'(bus.addr_valid), 32'(m_active));
        check("address",    32'(bus.address),    32'(e_addr));
        check("busy",       32'(bus.busy),       32'(e_busy));
        check("done",       32'(bus.done),       32'(m_done_due && !ab));
        if (bus.addr_valid && rdy) beats_seen++;

        if (e_busy && ab) begin
            if (m_active) m_hold = exp_q[0];
            exp_q.delete();
            m_active   = 1'b0;
            m_done_due = 1'b0;
        end else if (m_done_due) begin
            m_done_due = 1'b0;
        end else if (m_active) begin
            if (rdy) begin
                m_hold = exp_q.pop_front() + AW'(m_stride);
                if (exp_q.size() == 0) begin
                    m_active   = 1'b0;
                    m_done_due = 1'b1;
                end
            end
        end else if (st && !ab) begin
            if (l == '0) begin
                m_done_due = 1'b1;
            end else begin
                m_stride = s;
                for (int i = 0; i < int'(l); i++) begin
                    nxt = b + AW'(i * int'(s));
                    exp_q.push_back(nxt);
                end
                m_active = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cycle(1'b0, '0, '0, '0, 1'b0, rdy);
    endtask

    initial begin
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.stride    = '0;
        bus.abort     = 1'b0;
        bus.mem_ready = 1'b0;
        model_reset();
        #3;
        check("reset_address",    32'(bus.address),    32'h0);
        check("reset_addr_valid", 32'(bus.addr_valid), 32'h0);
        check("reset_busy",       32'(bus.busy),       32'h0);
        check("reset_done",       32'(bus.done),       32'h0);

        // Basic scan; start is presented on the first edge after reset release.
        cycle(1'b1, 16'h0010, 16'd4, 4'd1, 1'b0, 1'b1);
        idle(6, 1'b1);

        // Wrap through 0xFFFF.
        cycle(1'b1, 16'hFFFE, 16'd4, 4'd1, 1'b0, 1'b1);
        idle(6, 1'b1);

        // Backpressure on beat 2; exactly three beats must be accepted.
        beats_seen = 0;
        cycle(1'b1, 16'h0100, 16'd3, 4'd4, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0777, 16'd9, 4'd3, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b0, 1'b1);
        idle(3, 1'b1);
        check("stall_beat_count", 32'(beats_seen), 32'd3);

        // Zero-length start: done without any address.
        cycle(1'b1, 16'h1234, 16'd0, 4'd2, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Abort after three beats, then a normal single-beat scan.
        cycle(1'b1, 16'h0040, 16'd8, 4'd2, 1'b0, 1'b1);
        idle(3, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b1);
        idle(2, 1'b1);
        cycle(1'b1, 16'h0020, 16'd1, 4'd1, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Abort together with start in IDLE: start must be ignored.
        cycle(1'b1, 16'h0300, 16'd2, 4'd1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Asynchronous reset during beat 2, with a start while busy.
        cycle(1'b1, 16'h0200, 16'd5, 4'd1, 1'b0, 1'b1);
        cycle(1'b1, 16'h0500, 16'd2, 4'd3, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_address",    32'(bus.address),    32'h0);
        check("async_rst_addr_valid", 32'(bus.addr_valid), 32'h0);
        check("async_rst_busy",       32'(bus.busy),       32'h0);
        check("async_rst_done",       32'(bus.done),       32'h0);
        model_reset();
        bus.start = 1'b0;
        @(posedge clk);
        idle(4, 1'b1);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [AW-1:0] rb;
            rb = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF0 + $urandom_range(0, 15))
                                             : AW'($urandom);
            cycle($urandom_range(0, 2) == 0, rb, AW'($urandom_range(0, 6)),
                  SW'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        idle(12, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
